// File: rtl/parity_pop_scheduler_pkg.sv
// Shared types and parity helpers for the parity-tagged FIFO pop scheduler.
// Words are passed zero-extended to MAX_WORD_W so one function serves any payload width.
`timescale 1ns/1ps
package parity_pop_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      HALT  = 2'd2
   } sched_state_t;

   localparam int MAX_WORD_W = 64;

   // sel=1: parity bit sits just above the payload (bit dw); sel=0: bit 0
   function automatic logic parity_ok(input logic [MAX_WORD_W-1:0] word,
                                      input int                    dw,
                                      input logic                  sel,
                                      input logic                  even_odd);
      logic pbit;
      pbit = sel ? word[dw[5:0]] : word[0];
      return (pbit == even_odd);
   endfunction

   function automatic logic [MAX_WORD_W-1:0] strip_parity(input logic [MAX_WORD_W-1:0] word,
                                                           input int                    dw,
                                                           input logic                  sel);
      logic [MAX_WORD_W-1:0] mask;
      mask = (64'd1 << dw[5:0]) - 64'd1;
      return sel ? (word & mask) : ((word >> 1) & mask);
   endfunction

endpackage

// File: rtl/parity_pop_scheduler_if.sv
// FIFO pop side, receiver side and status signals of the scheduler.
// Handshake: a word moves when valid and ready are both high in the same cycle; pop_grant_fifo marks that cycle.
`timescale 1ns/1ps
interface parity_pop_scheduler_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_RX     = 2,
   parameter int ERR_CNT_W  = 8
);
   import parity_pop_scheduler_pkg::*;

   localparam int IDW = $clog2(NUM_RX);

   logic [DATA_WIDTH:0]   data_in;
   logic                  pop_valid_fifo;
   logic                  pop_grant_fifo;
   logic [NUM_RX-1:0]     rx_req;
   logic [NUM_RX-1:0]     pop_grant_receiver;
   logic [NUM_RX-1:0]     pop_valid_receiver;
   logic [DATA_WIDTH-1:0] data_out;
   logic [IDW-1:0]        owner_id;
   logic                  err_clear;
   logic                  err_pulse;
   logic [ERR_CNT_W-1:0]  err_count;
   logic                  halted;
   sched_state_t          dbg_state;
   logic [7:0]            dbg_burst_cnt;

   modport master (
      input  data_in, pop_valid_fifo, rx_req, pop_grant_receiver, err_clear,
      output pop_grant_fifo, pop_valid_receiver, data_out, owner_id,
             err_pulse, err_count, halted, dbg_state, dbg_burst_cnt
   );

   modport slave (
      output data_in, pop_valid_fifo, rx_req, pop_grant_receiver, err_clear,
      input  pop_grant_fifo, pop_valid_receiver, data_out, owner_id,
             err_pulse, err_count, halted, dbg_state, dbg_burst_cnt
   );

endinterface

// File: rtl/parity_pop_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last_owner, wrapping modulo N.
`timescale 1ns/1ps
module parity_pop_scheduler_rr_arbiter #(
   parameter int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last_owner,
   output logic [IW-1:0] o_grant_idx,
   output logic          o_any_req
);

   logic [IW-1:0] w_idx;
   logic          w_found;

   always_comb begin
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_idx       = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IW'((int'(i_last_owner) + k) % N);
         if (!w_found && i_req[w_idx]) begin
            w_found     = 1'b1;
            o_grant_idx = w_idx;
         end
      end
   end

   assign o_any_req = |i_req;

endmodule

// File: rtl/parity_pop_scheduler.sv
// Shares one parity-tagged FIFO pop port between NUM_RX receivers, round-robin with a burst limit.
// Bad-parity head words are either dropped and counted, or halt the port until err_clear.
`timescale 1ns/1ps
module parity_pop_scheduler
   import parity_pop_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH        = 8,
   parameter int NUM_RX            = 2,
   parameter int EVEN_ODD          = 0,
   parameter int SELECT_PARITY_BIT = 0,
   parameter int BURST_LEN         = 4,
   parameter int DROP_BAD          = 1,
   parameter int ERR_CNT_W         = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   parity_pop_scheduler_if.master bus
);

   localparam int IDW = $clog2(NUM_RX);
   localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0]        BURST_LAST = BW'(BURST_LEN - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

   sched_state_t         r_state;
   logic [IDW-1:0]       r_owner;
   logic [IDW-1:0]       r_last_owner;
   logic [BW-1:0]        r_burst_cnt;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic                 r_err_pulse;

   logic              w_good;
   logic              w_serve;
   logic              w_owner_req;
   logic              w_owner_rdy;
   logic              w_deliver;
   logic              w_xfer;
   logic              w_bad;
   logic              w_drop;
   logic              w_halt_drop;
   logic              w_burst_end;
   logic              w_any_req;
   logic [IDW-1:0]    w_grant_idx;
   logic [NUM_RX-1:0] w_valid_vec;

   parity_pop_scheduler_rr_arbiter #(.N(NUM_RX)) u_arb (
      .i_req        (bus.rx_req),
      .i_last_owner (r_last_owner),
      .o_grant_idx  (w_grant_idx),
      .o_any_req    (w_any_req)
   );

   assign w_good = parity_ok(MAX_WORD_W'(bus.data_in), DATA_WIDTH,
                             SELECT_PARITY_BIT != 0, EVEN_ODD != 0);
   assign bus.data_out = DATA_WIDTH'(strip_parity(MAX_WORD_W'(bus.data_in), DATA_WIDTH,
                                                  SELECT_PARITY_BIT != 0));

   // Handshake decode straight from registered state: zero-cycle datapath latency
   assign w_serve     = (r_state == SERVE);
   assign w_owner_req = bus.rx_req[r_owner];
   assign w_owner_rdy = bus.pop_grant_receiver[r_owner];
   assign w_deliver   = w_serve && bus.pop_valid_fifo && w_good;
   assign w_xfer      = w_deliver && w_owner_rdy;
   assign w_bad       = w_serve && bus.pop_valid_fifo && !w_good;
   assign w_drop      = w_bad && (DROP_BAD != 0);
   assign w_halt_drop = (r_state == HALT) && bus.err_clear && bus.pop_valid_fifo;
   assign w_burst_end = (r_burst_cnt == BURST_LAST);

   always_comb begin
      w_valid_vec = '0;
      if (w_deliver) w_valid_vec[r_owner] = 1'b1;
   end

   assign bus.pop_valid_receiver = w_valid_vec;
   assign bus.pop_grant_fifo     = w_xfer || w_drop || w_halt_drop;
   assign bus.owner_id           = r_owner;
   assign bus.err_pulse          = r_err_pulse;
   assign bus.err_count          = r_err_count;
   assign bus.halted             = (r_state == HALT);
   assign bus.dbg_state          = r_state;
   assign bus.dbg_burst_cnt      = 8'(r_burst_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_owner      <= '0;
         r_last_owner <= IDW'(NUM_RX - 1);
         r_burst_cnt  <= '0;
         r_err_count  <= '0;
         r_err_pulse  <= 1'b0;
      end else begin
         r_err_pulse <= w_drop || w_halt_drop;
         if ((w_drop || w_halt_drop) && (r_err_count != ERR_MAX))
            r_err_count <= r_err_count + 1'b1;

         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner     <= w_grant_idx;
                  r_burst_cnt <= '0;
                  r_state     <= SERVE;
               end
            end
            SERVE: begin
               // A transfer always completes before a dropped request is honoured
               if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
                  if (w_burst_end) begin
                     r_last_owner <= r_owner;
                     r_state      <= IDLE;
                  end
               end else if (w_bad && (DROP_BAD == 0)) begin
                  r_state <= HALT;
               end else if (!w_owner_req) begin
                  r_last_owner <= r_owner;
                  r_state      <= IDLE;
               end
            end
            HALT: begin
               if (bus.err_clear) begin
                  r_last_owner <= r_owner;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parity_pop_scheduler.sv
// Directed bench: three scheduler instances (drop mode, halt mode, 2-bit error counter) on shared stimulus.
// Inputs change on the falling edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_parity_pop_scheduler;
   import parity_pop_scheduler_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] d_data = '0;
   logic       d_pvf = 1'b0;
   logic [1:0] d_req = '0;
   logic [1:0] d_rdy = '0;
   logic       d_clr = 1'b0;
   logic       w_grant;
   int         sel = 0;
   int         errors = 0;
   int         checks = 0;
   logic [8:0] fifo_q[$];

   always #5 clk = ~clk;

   parity_pop_scheduler_if ifa ();
   parity_pop_scheduler_if ifh ();
   parity_pop_scheduler_if #(.ERR_CNT_W(2)) ifs ();

   assign ifa.data_in = d_data;  assign ifa.pop_valid_fifo = d_pvf;  assign ifa.rx_req = d_req;
   assign ifa.pop_grant_receiver = d_rdy;  assign ifa.err_clear = d_clr;
   assign ifh.data_in = d_data;  assign ifh.pop_valid_fifo = d_pvf;  assign ifh.rx_req = d_req;
   assign ifh.pop_grant_receiver = d_rdy;  assign ifh.err_clear = d_clr;
   assign ifs.data_in = d_data;  assign ifs.pop_valid_fifo = d_pvf;  assign ifs.rx_req = d_req;
   assign ifs.pop_grant_receiver = d_rdy;  assign ifs.err_clear = d_clr;

   parity_pop_scheduler #(.DROP_BAD(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   parity_pop_scheduler #(.DROP_BAD(0)) dut_h (.clk(clk), .rst_n(rst_n), .bus(ifh));
   parity_pop_scheduler #(.DROP_BAD(1), .ERR_CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));

   always_comb begin
      case (sel)
         1:       w_grant = ifh.pop_grant_fifo;
         2:       w_grant = ifs.pop_grant_fifo;
         default: w_grant = ifa.pop_grant_fifo;
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int which);
      sel = which;
      fifo_q.delete();
      d_req = '0; d_rdy = '0; d_clr = 1'b0; d_pvf = 1'b0; d_data = '0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic present(input logic [1:0] req, input logic [1:0] rdy, input logic clr);
      @(negedge clk);
      d_req = req; d_rdy = rdy; d_clr = clr;
      d_pvf = (fifo_q.size() != 0);
      d_data = d_pvf ? fifo_q[0] : 9'h000;
      #1;
   endtask

   task automatic commit();
      if (w_grant && fifo_q.size() != 0) void'(fifo_q.pop_front());
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset(0);
      fifo_q.push_back({8'h22, 1'b1});
      fifo_q.push_back({8'h44, 1'b0});
      present(2'b10, 2'b00, 1'b0); commit();
      present(2'b10, 2'b00, 1'b0); commit();
      present(2'b10, 2'b00, 1'b0);
      checks++; if (ifa.err_count !== 8'd1) begin errors++; $display("FAIL rst_pre_errcnt got %0d want 1", ifa.err_count); end
      checks++; if (ifa.pop_valid_receiver !== 2'b10) begin errors++; $display("FAIL rst_pre_valid got %b want 10", ifa.pop_valid_receiver); end
      commit();
      #1 rst_n = 1'b0; d_req = 2'b00;
      #1;
      checks++; if (ifa.pop_valid_receiver !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", ifa.pop_valid_receiver); end
      checks++; if (ifa.pop_grant_fifo !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", ifa.pop_grant_fifo); end
      checks++; if (ifa.err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d want 0", ifa.err_count); end
      checks++; if (ifa.owner_id !== 1'b0) begin errors++; $display("FAIL rst_owner got %0d want 0", ifa.owner_id); end
      checks++; if (ifa.dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", ifa.dbg_state); end
      @(negedge clk); rst_n = 1'b1;
      present(2'b11, 2'b00, 1'b0);
      checks++; if (ifa.pop_valid_receiver !== 2'b00) begin errors++; $display("FAIL rst_arb_cycle got %b want 00", ifa.pop_valid_receiver); end
      commit();
      present(2'b11, 2'b00, 1'b0);
      checks++; if (ifa.pop_valid_receiver !== 2'b01) begin errors++; $display("FAIL rst_first_owner got %b want 01", ifa.pop_valid_receiver); end
      checks++; if (ifa.data_out !== 8'h44) begin errors++; $display("FAIL rst_first_data got %h want 44", ifa.data_out); end
      commit();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_v [14] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                                 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
      logic [7:0] nxt = 8'h01;
      do_reset(0);
      for (int i = 1; i <= 10; i++) fifo_q.push_back({8'(i), 1'b0});
      for (int c = 0; c < 14; c++) begin
         present(2'b11, 2'b11, 1'b0);
         checks++; if (ifa.pop_valid_receiver !== exp_v[c]) begin errors++; $display("FAIL rr_valid c%0d got %b want %b", c, ifa.pop_valid_receiver, exp_v[c]); end
         checks++; if (ifa.pop_grant_fifo !== (exp_v[c] != 2'b00)) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", c, ifa.pop_grant_fifo, exp_v[c] != 2'b00); end
         if (exp_v[c] != 2'b00) begin
            checks++; if (ifa.data_out !== nxt) begin errors++; $display("FAIL rr_data c%0d got %h want %h", c, ifa.data_out, nxt); end
            nxt = nxt + 8'h01;
         end
         commit();
      end
   endtask

   task automatic test_drop_bad();
      do_reset(0);
      fifo_q.push_back({8'h11, 1'b0});
      fifo_q.push_back({8'h22, 1'b1});
      fifo_q.push_back({8'h33, 1'b0});
      present(2'b01, 2'b01, 1'b0); commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifa.pop_valid_receiver !== 2'b01 || ifa.data_out !== 8'h11) begin errors++; $display("FAIL drop_first got v=%b d=%h want v=01 d=11", ifa.pop_valid_receiver, ifa.data_out); end
      commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifa.pop_valid_receiver !== 2'b00 || ifa.pop_grant_fifo !== 1'b1) begin errors++; $display("FAIL drop_pop got v=%b g=%b want v=00 g=1", ifa.pop_valid_receiver, ifa.pop_grant_fifo); end
      checks++; if (ifa.err_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_early got %b want 0", ifa.err_pulse); end
      commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifa.err_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", ifa.err_pulse); end
      checks++; if (ifa.err_count !== 8'd1) begin errors++; $display("FAIL drop_errcnt got %0d want 1", ifa.err_count); end
      checks++; if (ifa.pop_valid_receiver !== 2'b01 || ifa.data_out !== 8'h33) begin errors++; $display("FAIL drop_second got v=%b d=%h want v=01 d=33", ifa.pop_valid_receiver, ifa.data_out); end
      commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifa.err_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b want 0", ifa.err_pulse); end
      checks++; if (ifa.dbg_burst_cnt !== 8'd2) begin errors++; $display("FAIL drop_burst got %0d want 2", ifa.dbg_burst_cnt); end
      commit();
   endtask

   task automatic test_halt();
      do_reset(1);
      fifo_q.push_back({8'h5A, 1'b1});
      fifo_q.push_back({8'h5B, 1'b0});
      present(2'b01, 2'b01, 1'b0); commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifh.pop_grant_fifo !== 1'b0 || ifh.halted !== 1'b0) begin errors++; $display("FAIL halt_detect got g=%b h=%b want g=0 h=0", ifh.pop_grant_fifo, ifh.halted); end
      commit();
      for (int c = 0; c < 5; c++) begin
         present(2'b01, 2'b01, 1'b0);
         checks++; if (ifh.halted !== 1'b1 || ifh.pop_grant_fifo !== 1'b0 || ifh.pop_valid_receiver !== 2'b00) begin errors++; $display("FAIL halt_hold c%0d got h=%b g=%b v=%b want h=1 g=0 v=00", c, ifh.halted, ifh.pop_grant_fifo, ifh.pop_valid_receiver); end
         commit();
      end
      present(2'b01, 2'b01, 1'b1);
      checks++; if (ifh.pop_grant_fifo !== 1'b1) begin errors++; $display("FAIL halt_clear_pop got %b want 1", ifh.pop_grant_fifo); end
      commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifh.halted !== 1'b0 || ifh.dbg_state !== IDLE) begin errors++; $display("FAIL halt_release got h=%b s=%0d want h=0 s=IDLE", ifh.halted, ifh.dbg_state); end
      checks++; if (ifh.err_count !== 8'd1 || ifh.err_pulse !== 1'b1) begin errors++; $display("FAIL halt_errcnt got c=%0d p=%b want c=1 p=1", ifh.err_count, ifh.err_pulse); end
      commit();
      present(2'b01, 2'b01, 1'b0);
      checks++; if (ifh.pop_valid_receiver !== 2'b01 || ifh.data_out !== 8'h5B || ifh.pop_grant_fifo !== 1'b1) begin errors++; $display("FAIL halt_resume got v=%b d=%h g=%b want v=01 d=5b g=1", ifh.pop_valid_receiver, ifh.data_out, ifh.pop_grant_fifo); end
      commit();
   endtask

   task automatic test_stall();
      do_reset(0);
      fifo_q.push_back({8'hC3, 1'b0});
      fifo_q.push_back({8'hD4, 1'b0});
      present(2'b11, 2'b00, 1'b0); commit();
      for (int c = 0; c < 3; c++) begin
         present(2'b11, 2'b00, 1'b0);
         checks++; if (ifa.pop_valid_receiver !== 2'b01 || ifa.pop_grant_fifo !== 1'b0 || ifa.data_out !== 8'hC3) begin errors++; $display("FAIL stall_hold c%0d got v=%b g=%b d=%h want v=01 g=0 d=c3", c, ifa.pop_valid_receiver, ifa.pop_grant_fifo, ifa.data_out); end
         commit();
      end
      present(2'b10, 2'b00, 1'b0);
      checks++; if (ifa.dbg_state !== SERVE || ifa.pop_grant_fifo !== 1'b0) begin errors++; $display("FAIL stall_drop_req got s=%0d g=%b want s=SERVE g=0", ifa.dbg_state, ifa.pop_grant_fifo); end
      commit();
      present(2'b10, 2'b00, 1'b0);
      checks++; if (ifa.dbg_state !== IDLE || ifa.pop_valid_receiver !== 2'b00) begin errors++; $display("FAIL stall_idle got s=%0d v=%b want s=IDLE v=00", ifa.dbg_state, ifa.pop_valid_receiver); end
      commit();
      present(2'b10, 2'b00, 1'b0);
      checks++; if (ifa.pop_valid_receiver !== 2'b10 || ifa.owner_id !== 1'b1 || ifa.data_out !== 8'hC3) begin errors++; $display("FAIL stall_rx1 got v=%b o=%0d d=%h want v=10 o=1 d=c3", ifa.pop_valid_receiver, ifa.owner_id, ifa.data_out); end
      commit();
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      int pulses = 0;
      do_reset(2);
      for (int i = 0; i < 5; i++) fifo_q.push_back({8'hE0 + 8'(i), 1'b1});
      present(2'b01, 2'b01, 1'b0); commit();
      for (int c = 1; c <= 7; c++) begin
         present(2'b01, 2'b01, 1'b0);
         if (ifs.err_pulse === 1'b1) pulses++;
         if (c <= 5) begin
            checks++; if (ifs.pop_grant_fifo !== 1'b1 || ifs.pop_valid_receiver !== 2'b00) begin errors++; $display("FAIL sat_drop c%0d got g=%b v=%b want g=1 v=00", c, ifs.pop_grant_fifo, ifs.pop_valid_receiver); end
         end
         if (c >= 2 && c <= 6) begin
            checks++; if (ifs.err_count !== exp_c[c-2]) begin errors++; $display("FAIL sat_count c%0d got %0d want %0d", c, ifs.err_count, exp_c[c-2]); end
         end
         commit();
      end
      checks++; if (pulses != 5) begin errors++; $display("FAIL sat_pulses got %0d want 5", pulses); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_drop_bad();
      test_halt();
      test_stall();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
